ghash64: RTL

//   GHASH authentication stage directly downstream of the GCTR/PRESENT-80 counter-mode

---
 rtl/gcm_pkg.sv | 23 ++
 rtl/ghash64_if.sv | 27 ++
 rtl/gf64_mul_serial.sv | 60 ++++++
 rtl/ghash64.sv | 89 ++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// Shared GCM/GHASH definitions: block geometry, field polynomial, FSM encoding and
// the partial-block masking helper.
package gcm_pkg;

  localparam int          GCM_BLK_W = 64;
  localparam int          GCM_CNT_W = 6;
  localparam logic [63:0] GF64_POLY = 64'h1B;

  typedef logic [1:0] ghash_state_t;

  localparam ghash_state_t ST_IDLE  = 2'd0;
  localparam ghash_state_t ST_READY = 2'd1;
  localparam ghash_state_t ST_MUL   = 2'd2;
  localparam ghash_state_t ST_TAG   = 2'd3;

  // Keeps the top vbits bits of a block; 0 or anything above 64 means a full block.
  function automatic logic [GCM_BLK_W-1:0] vbits_mask(input logic [6:0] vbits);
    logic [6:0] n;
    n = ((vbits == 7'd0) || (vbits > 7'd64)) ? 7'd64 : vbits;
    vbits_mask = ~({GCM_BLK_W{1'b1}} >> n);
  endfunction

endpackage

// File: rtl/ghash64_if.sv
// Block-in / tag-out bus between the GCTR front end, the GHASH stage and tag logic.
interface ghash64_if;
  import gcm_pkg::*;

  logic                 start;
  logic [GCM_BLK_W-1:0] h_key;
  logic                 in_valid;
  logic                 in_ready;
  logic [GCM_BLK_W-1:0] in_data;
  logic [6:0]           in_vbits;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [GCM_BLK_W-1:0] out_tag;
  logic                 busy;

  modport master (
    output start, h_key, in_valid, in_data, in_vbits, in_last, out_ready,
    input  in_ready, out_valid, out_tag, busy
  );

  modport slave (
    input  start, h_key, in_valid, in_data, in_vbits, in_last, out_ready,
    output in_ready, out_valid, out_tag, busy
  );

endinterface

// File: rtl/gf64_mul_serial.sv
// Bit-serial GF(2^64) multiplier, Horner form MSB-first: one bit of A per cycle.
module gf64_mul_serial
  import gcm_pkg::*;
#(
  parameter int               BLK_W = GCM_BLK_W,
  parameter int               CNT_W = GCM_CNT_W,
  parameter logic [BLK_W-1:0] POLY  = GF64_POLY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [BLK_W-1:0] a_i,
  input  logic [BLK_W-1:0] h_i,
  output logic             done_o,
  output logic [BLK_W-1:0] p_o
);

  logic [BLK_W-1:0] a_q, a_d;
  logic [BLK_W-1:0] z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  // p_o is the next Z; on the done cycle it is the finished product.
  always_comb begin
    a_d    = a_q;
    z_d    = z_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    p_o    = {z_q[BLK_W-2:0], 1'b0} ^ (z_q[BLK_W-1] ? POLY : '0) ^ (a_q[cnt_q] ? h_i : '0);
    done_o = run_q && (cnt_q == '0);
    if (abort_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      a_d   = a_i;
      z_d   = '0;
      cnt_d = '1;
      run_d = 1'b1;
    end else if (run_q) begin
      z_d = p_o;
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      z_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      z_q   <= z_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/ghash64.sv
// GHASH over 64-bit ciphertext blocks: Y = (Y ^ X) * H, tag presented after the last block.
module ghash64
  import gcm_pkg::*;
#(
  parameter int               BLK_W = GCM_BLK_W,
  parameter logic [BLK_W-1:0] POLY  = GF64_POLY,
  parameter int               CNT_W = GCM_CNT_W
) (
  input  logic     clk,
  input  logic     reset,
  ghash64_if.slave bus
);

  ghash_state_t     state_q, state_d;
  logic [BLK_W-1:0] y_q, y_d;
  logic [BLK_W-1:0] h_q, h_d;
  logic             last_q, last_d;
  logic             accept, abort;
  logic             mul_done;
  logic [BLK_W-1:0] mul_p;
  logic [BLK_W-1:0] mul_a;

  assign mul_a = y_q ^ (bus.in_data & vbits_mask(bus.in_vbits));

  // start overrides everything, including a block offered in the same cycle.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    h_d     = h_q;
    last_d  = last_q;
    accept  = 1'b0;
    abort   = 1'b0;
    if (bus.start) begin
      state_d = ST_READY;
      y_d     = '0;
      h_d     = bus.h_key;
      abort   = 1'b1;
    end else begin
      case (state_q)
        ST_READY: if (bus.in_valid) begin
          accept  = 1'b1;
          last_d  = bus.in_last;
          state_d = ST_MUL;
        end
        ST_MUL: if (mul_done) begin
          y_d     = mul_p;
          state_d = last_q ? ST_TAG : ST_READY;
        end
        ST_TAG: if (bus.out_ready) state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      h_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      h_q     <= h_d;
      last_q  <= last_d;
    end
  end

  gf64_mul_serial #(
    .BLK_W (BLK_W),
    .CNT_W (CNT_W),
    .POLY  (POLY)
  ) u_mul (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (accept),
    .abort_i (abort),
    .a_i     (mul_a),
    .h_i     (h_q),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

  assign bus.in_ready  = (state_q == ST_READY);
  assign bus.out_valid = (state_q == ST_TAG);
  assign bus.out_tag   = y_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
